// File: rtl/pps_conditioner.sv
// pps_conditioner
//   Qualifies the raw GPS 1PPS input for the reset/channel generator.
//   The raw input is synchronised into clk, and any high run shorter than
//   MIN_HIGH cycles is dropped. Each qualified rising edge gives one
//   registered strobe. The interval between strobes is measured and used
//   to report lock and loss of the reference.
//
// Ports
//   clk         in   1      system clock
//   rst         in   1      asynchronous, active-high reset
//   pps_in      in   1      raw 1PPS, asynchronous to clk
//   pps_pulse   out  1      one-cycle qualified PPS strobe (registered)
//   pps_locked  out  1      last VALID_N intervals all within CLK_HZ +/- TOL
//   pps_lost    out  1      no qualified pulse for more than CLK_HZ+TOL cycles
//   period_cnt  out  CNT_W  last measured interval in clk cycles
module pps_conditioner #(
    parameter int unsigned CLK_HZ   = 20_000_000,
    parameter int unsigned TOL      = 2_000,
    parameter int unsigned MIN_HIGH = 4,
    parameter int unsigned VALID_N  = 3,
    parameter int unsigned CNT_W    = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pps_in,
    output logic             pps_pulse,
    output logic             pps_locked,
    output logic             pps_lost,
    output logic [CNT_W-1:0] period_cnt
);

    localparam int unsigned HI_W = $clog2(MIN_HIGH + 1);
    localparam int unsigned GR_W = $clog2(VALID_N + 1);

    localparam logic [HI_W-1:0]  HI_LAST  = HI_W'(MIN_HIGH - 1);
    localparam logic [HI_W-1:0]  HI_SAT   = HI_W'(MIN_HIGH);
    localparam logic [GR_W-1:0]  GR_SAT   = GR_W'(VALID_N);
    localparam logic [GR_W:0]    GR_NEED  = (GR_W + 1)'(VALID_N);
    localparam logic [CNT_W:0]   LO_LIM   = (CNT_W + 1)'(CLK_HZ - TOL);
    localparam logic [CNT_W:0]   HI_LIM   = (CNT_W + 1)'(CLK_HZ + TOL);
    localparam logic [CNT_W-1:0] LOSS_IVL = CNT_W'(CLK_HZ + TOL);

    logic             s1_q, s2_q;
    logic [HI_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] ivl_q, ivl_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic             first_seen_q, first_seen_d;
    logic             pulse_q, pulse_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] period_q, period_d;

    logic             ev;
    logic             loss;
    logic             in_tol;
    logic [CNT_W:0]   ivl_inc;
    logic [GR_W:0]    gr_inc;

    always_comb begin
        // Event fires on the cycle the run reaches MIN_HIGH; the counter then
        // saturates past HI_LAST so a held-high input cannot retrigger.
        ev      = s2_q && (hi_cnt_q == HI_LAST);
        // Measured interval is judged one bit wider so ivl at all-ones
        // cannot wrap into the tolerance window.
        ivl_inc = {1'b0, ivl_q} + 1'b1;
        in_tol  = (ivl_inc >= LO_LIM) && (ivl_inc <= HI_LIM);
        gr_inc  = {1'b0, good_run_q} + 1'b1;
        // An event in the same cycle pre-empts the loss declaration.
        loss    = !ev && (ivl_q == LOSS_IVL);

        if (!s2_q) begin
            hi_cnt_d = '0;
        end else if (hi_cnt_q == HI_SAT) begin
            hi_cnt_d = hi_cnt_q;
        end else begin
            hi_cnt_d = hi_cnt_q + 1'b1;
        end

        if (ev) begin
            ivl_d = '0;
        end else if (&ivl_q) begin
            ivl_d = ivl_q;
        end else begin
            ivl_d = ivl_q + 1'b1;
        end

        pulse_d      = ev;
        good_run_d   = good_run_q;
        first_seen_d = first_seen_q;
        locked_d     = locked_q;
        lost_d       = lost_q;
        period_d     = period_q;

        if (ev) begin
            period_d     = ivl_inc[CNT_W-1:0];
            first_seen_d = 1'b1;
            lost_d       = 1'b0;
            // The first event after reset or loss only re-arms the judge.
            if (first_seen_q) begin
                if (in_tol) begin
                    good_run_d = (good_run_q == GR_SAT) ? good_run_q : good_run_q + 1'b1;
                    locked_d   = (gr_inc >= GR_NEED);
                end else begin
                    good_run_d = '0;
                    locked_d   = 1'b0;
                end
            end
        end else if (loss) begin
            lost_d       = 1'b1;
            locked_d     = 1'b0;
            good_run_d   = '0;
            first_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            hi_cnt_q     <= '0;
            ivl_q        <= '0;
            good_run_q   <= '0;
            first_seen_q <= 1'b0;
            pulse_q      <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            period_q     <= '0;
        end else begin
            s1_q         <= pps_in;
            s2_q         <= s1_q;
            hi_cnt_q     <= hi_cnt_d;
            ivl_q        <= ivl_d;
            good_run_q   <= good_run_d;
            first_seen_q <= first_seen_d;
            pulse_q      <= pulse_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            period_q     <= period_d;
        end
    end

    assign pps_pulse  = pulse_q;
    assign pps_locked = locked_q;
    assign pps_lost   = lost_q;
    assign period_cnt = period_q;

endmodule

// File: tb/tb_pps_conditioner.sv
// tb_pps_conditioner
//   Scoreboard bench for pps_conditioner with a shortened 1000-cycle second.
//   Each qualifying stimulus pulse pushes the expected strobe cycle, period,
//   lock and loss state; a monitor pops and compares on every strobe.
module tb_pps_conditioner;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned TOL      = 10;
    localparam int unsigned MIN_HIGH = 4;
    localparam int unsigned VALID_N  = 3;
    localparam int unsigned CNT_W    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             pps_in;
    logic             pps_pulse;
    logic             pps_locked;
    logic             pps_lost;
    logic [CNT_W-1:0] period_cnt;

    pps_conditioner #(
        .CLK_HZ  (CLK_HZ),
        .TOL     (TOL),
        .MIN_HIGH(MIN_HIGH),
        .VALID_N (VALID_N),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pps_in    (pps_in),
        .pps_pulse (pps_pulse),
        .pps_locked(pps_locked),
        .pps_lost  (pps_lost),
        .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; edge n leaves cyc == n.
    int unsigned cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int unsigned      at;
        logic [CNT_W-1:0] period;
        logic             locked;
        logic             lost;
    } exp_t;

    exp_t sb[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    int unsigned last_ev;
    bit          m_first;
    int unsigned m_good;
    bit          m_locked;
    bit          m_lost;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_ev  = 0;
        m_first  = 1'b0;
        m_good   = 0;
        m_locked = 1'b0;
        m_lost   = 1'b0;
    endtask

    // Expected outcome of a qualified event at rising edge n_e.
    task automatic model_event(input int unsigned n_e);
        int unsigned p;
        exp_t e;
        p = n_e - last_ev;
        if (p > CLK_HZ + TOL + 1) begin
            m_lost   = 1'b1;
            m_locked = 1'b0;
            m_good   = 0;
            m_first  = 1'b0;
        end
        if (m_first) begin
            if (p >= CLK_HZ - TOL && p <= CLK_HZ + TOL) begin
                if (m_good < VALID_N) m_good++;
                m_locked = (m_good >= VALID_N);
            end else begin
                m_good   = 0;
                m_locked = 1'b0;
            end
        end
        m_first  = 1'b1;
        m_lost   = 1'b0;
        last_ev  = n_e;
        e.at     = n_e;
        e.period = CNT_W'(p);
        e.locked = m_locked;
        e.lost   = m_lost;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && pps_pulse) begin
            if (sb.size() == 0) begin
                check_eq("pulse_pending", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("pulse_cycle", cyc, e.at);
                check_eq("period_cnt", period_cnt, e.period);
                check_eq("pulse_locked", pps_locked, e.locked);
                check_eq("pulse_lost", pps_lost, e.lost);
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: holds pps_in high for h samples and returns
    // 'spacing' cycles after the start, ready for the next pulse.
    task automatic send_pulse(input int unsigned h, input int unsigned spacing);
        int unsigned n_s;
        n_s = cyc + 1;
        if (h >= MIN_HIGH) model_event(n_s + MIN_HIGH + 1);
        pps_in = 1'b1;
        wait_cyc(h);
        pps_in = 1'b0;
        if (spacing > h) wait_cyc(spacing - h);
    endtask

    task automatic wait_until_cyc(input int unsigned target);
        int unsigned b;
        b = 0;
        while (cyc != target && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 5000) check_eq("wait_timeout", cyc, target);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pulse"}, pps_pulse, 0);
        check_eq({tag, "_locked"}, pps_locked, 0);
        check_eq({tag, "_lost"}, pps_lost, 0);
        check_eq({tag, "_period"}, period_cnt, 0);
    endtask

    // Asserted between edges so the asynchronous clear is observable at once.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_all_zero(tag);
        wait_cyc(3);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst    = 1'b0;
        pps_in = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset("rst_init");

        // Long high level: one strobe only, five edges after the first sample.
        wait_cyc(20);
        send_pulse(10, 100);
        check_eq("t1_drained", sb.size(), 0);

        apply_reset("rst_t2");

        // Glitch ignored; the following valid pulse is the first event.
        wait_cyc(30);
        send_pulse(3, 500);
        send_pulse(5, 1000);

        // Nominal intervals, then a single 1011 interval and three at 990.
        send_pulse(5, 1000);
        send_pulse(5, 1000);
        send_pulse(5, 1000);
        check_eq("t3_locked", pps_locked, 1);
        send_pulse(5, 1011);
        send_pulse(5, 990);
        send_pulse(5, 990);
        send_pulse(5, 990);
        send_pulse(5, 5);
        wait_cyc(2);
        check_eq("t4_relocked", pps_locked, 1);

        // Stop the input: loss lands on the edge after ivl reaches CLK_HZ+TOL.
        wait_until_cyc(last_ev + CLK_HZ + TOL);
        check_eq("t5_lost_early", pps_lost, 0);
        check_eq("t5_locked_before", pps_locked, 1);
        @(negedge clk);
        check_eq("t5_lost", pps_lost, 1);
        check_eq("t5_locked_after", pps_locked, 0);
        wait_cyc(300);
        send_pulse(5, 1000);
        send_pulse(5, 1000);
        send_pulse(5, 1000);
        send_pulse(5, 1000);
        check_eq("t5_relocked", pps_locked, 1);

        // Reset while the strobe is high and the block is locked.
        send_pulse(5, 5);
        wait_until_cyc(last_ev);
        check_eq("t6_pulse_high", pps_pulse, 1);
        apply_reset("t6_rst");
        wait_cyc(300);
        send_pulse(5, 1000);
        send_pulse(5, 50);
        check_eq("t6_not_locked", pps_locked, 0);
        check_eq("final_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
